// File: rtl/seven_seg_scanner.sv
// Four-digit common-anode seven-segment scanner with sequential double-dabble
// binary-to-BCD conversion; the 10 kHz input is edge-detected as data.
module seven_seg_scanner #(
  parameter int BIN_WIDTH     = 14,
  parameter int REFRESH_TICKS = 10
) (
  input  logic                 clk_100mHz_in,
  input  logic                 reset,
  input  logic                 clk_10kHz_in,
  input  logic [BIN_WIDTH-1:0] value_in,
  input  logic                 value_valid,
  input  logic                 blank_leading_zeros,
  output logic                 busy,
  output logic                 overflow,
  output logic [6:0]           seg_out,
  output logic                 dp_out,
  output logic [3:0]           an_out
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;

  localparam int CW  = $clog2(BIN_WIDTH + 1);
  localparam int CTW = $clog2(REFRESH_TICKS + 1);
  localparam logic [CW-1:0]        BIT_LAST  = CW'(BIN_WIDTH - 1);
  localparam logic [CTW-1:0]       CNT_LAST  = CTW'(REFRESH_TICKS - 1);
  localparam logic [BIN_WIDTH-1:0] MAX_VALUE = BIN_WIDTH'(9999);

  logic [1:0]              state;
  logic [BIN_WIDTH-1:0]    latched;
  logic [BIN_WIDTH-1:0]    shreg;
  logic [15:0]             scratch;
  logic [15:0]             adjusted;
  logic [BIN_WIDTH+15:0]   shifted;
  logic [CW-1:0]           bitcnt;
  logic [15:0]             digits;
  logic                    prev;
  logic                    tick;
  logic [CTW-1:0]          counter;
  logic [1:0]              idx;
  logic [3:0]              digit;
  logic                    upper_zero;
  logic [6:0]              pattern;

  assign tick   = clk_10kHz_in & ~prev;
  assign busy   = (state != IDLE);
  assign dp_out = 1'b1;

  // One double-dabble iteration: add-3 correction, then shift {scratch, value}.
  always_comb begin
    adjusted = scratch;
    for (int unsigned i = 0; i < 4; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adjusted[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
    shifted = {adjusted, shreg} << 1;
  end

  always_ff @(posedge clk_100mHz_in) begin
    if (reset) begin
      state    <= IDLE;
      latched  <= '0;
      shreg    <= '0;
      scratch  <= '0;
      bitcnt   <= '0;
      digits   <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid) begin
            latched <= value_in;
            shreg   <= value_in;
            scratch <= '0;
            bitcnt  <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted[BIN_WIDTH+15:BIN_WIDTH];
          shreg   <= shifted[BIN_WIDTH-1:0];
          bitcnt  <= bitcnt + CW'(1);
          if (bitcnt == BIT_LAST)
            state <= COMMIT;
        end
        COMMIT: begin
          digits   <= scratch;
          overflow <= (latched > MAX_VALUE);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_100mHz_in) begin
    if (reset) begin
      prev    <= 1'b0;
      counter <= '0;
      idx     <= '0;
    end else begin
      prev <= clk_10kHz_in;
      if (tick) begin
        if (counter == CNT_LAST) begin
          counter <= '0;
          idx     <= idx + 2'd1;
        end else begin
          counter <= counter + CTW'(1);
        end
      end
    end
  end

  always_comb begin
    digit = digits[{idx, 2'b00} +: 4];
    case (idx)
      2'd1:    upper_zero = (digits[15:4]  == 12'd0);
      2'd2:    upper_zero = (digits[15:8]  == 8'd0);
      2'd3:    upper_zero = (digits[15:12] == 4'd0);
      default: upper_zero = 1'b0;
    endcase
    if (overflow) begin
      pattern = 7'h3F;
    end else if (blank_leading_zeros && upper_zero) begin
      pattern = 7'h7F;
    end else begin
      case (digit)
        4'd0:    pattern = 7'h40;
        4'd1:    pattern = 7'h79;
        4'd2:    pattern = 7'h24;
        4'd3:    pattern = 7'h30;
        4'd4:    pattern = 7'h19;
        4'd5:    pattern = 7'h12;
        4'd6:    pattern = 7'h02;
        4'd7:    pattern = 7'h78;
        4'd8:    pattern = 7'h00;
        4'd9:    pattern = 7'h10;
        default: pattern = 7'h7F;
      endcase
    end
  end

  always_ff @(posedge clk_100mHz_in) begin
    if (reset) begin
      seg_out <= 7'h7F;
      an_out  <= 4'hF;
    end else begin
      seg_out <= pattern;
      an_out  <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: each digit-slot change of the scan is
// predicted from a decimal model of the displayed value and checked by a monitor.
module tb_seven_seg_scanner;
  localparam int BW = 14;
  localparam int RT = 10;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clk10 = 1'b0;
  logic [BW-1:0] value_in = '0;
  logic          value_valid = 1'b0;
  logic          blank = 1'b0;
  logic          busy, overflow, dp_out;
  logic [6:0]    seg_out;
  logic [3:0]    an_out;

  seven_seg_scanner #(.BIN_WIDTH(BW), .REFRESH_TICKS(RT)) dut (
    .clk_100mHz_in       (clk),
    .reset               (reset),
    .clk_10kHz_in        (clk10),
    .value_in            (value_in),
    .value_valid         (value_valid),
    .blank_leading_zeros (blank),
    .busy                (busy),
    .overflow            (overflow),
    .seg_out             (seg_out),
    .dp_out              (dp_out),
    .an_out              (an_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  int   m_value = 0;
  int   m_ticks = 0;
  bit   mon_en  = 1'b0;
  logic [3:0] last_an = 4'hF;
  int   pow10[4] = '{1, 10, 100, 1000};
  logic [6:0] dec[10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                          7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [6:0] ref_pat(input int k);
    if (m_value > 9999) return 7'h3F;
    if (blank && k != 0 && m_value < pow10[k]) return 7'h7F;
    return dec[(m_value / pow10[k]) % 10];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: every RT-th rising edge of the 10 kHz input moves to the next digit.
  task automatic model_tick();
    exp_t e;
    int k;
    m_ticks++;
    if (m_ticks % RT == 0) begin
      k = (m_ticks / RT) % 4;
      e.an  = ~(4'b0001 << k);
      e.seg = ref_pat(k);
      q.push_back(e);
    end
  endtask

  task automatic tick();
    clk10 = 1'b1;
    model_tick();
    step(); step();
    clk10 = 1'b0;
    step(); step();
  endtask

  task automatic scan_frame();
    repeat (4 * RT) tick();
    check("queue_drained", q.size(), 0);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    clk10 = 1'b0;
    value_valid = 1'b0;
    q.delete();
    m_ticks = 0;
    m_value = 0;
    repeat (3) step();
    @(negedge clk);
    check("reset_seg", seg_out, 7'h7F);
    check("reset_an", an_out, 4'hF);
    check("reset_dp", dp_out, 1'b1);
    check("reset_busy", busy, 1'b0);
    reset = 1'b0;
    step();
    @(negedge clk);
    check("post_reset_an", an_out, 4'hE);
    check("post_reset_seg", seg_out, 7'h40);
    step();
    mon_en = 1'b1;
  endtask

  task automatic convert(input int v);
    int hi = 0;
    value_in = BW'(v);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    m_value = v;
    for (int i = 0; i < BW + 1; i++) begin
      @(negedge clk);
      if (busy) hi++;
      step();
    end
    check("busy_window", hi, BW + 1);
    @(negedge clk);
    check("busy_done", busy, 1'b0);
    check("overflow", overflow, (v > 9999) ? 1 : 0);
    step();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && an_out !== last_an) begin
        if (q.size() == 0) begin
          total++;
          $display("FAIL scan_unexpected: an_out %h -> %h, expected no change", last_an, an_out);
        end else begin
          e = q.pop_front();
          check("scan_an", an_out, e.an);
          check("scan_seg", seg_out, e.seg);
        end
      end
      last_an = an_out;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int v;
    int waited;
    do_reset();

    blank = 1'b0;
    convert(1234);
    scan_frame();

    blank = 1'b1; convert(7); scan_frame();
    blank = 1'b0; scan_frame();
    blank = 1'b1; convert(0); scan_frame();

    blank = 1'b0; convert(12000); scan_frame();
    convert(9999); scan_frame();

    // Level held high must count as a single edge; align it to a slot boundary.
    while (m_ticks % RT != RT - 1) tick();
    clk10 = 1'b1;
    model_tick();
    repeat (100) step();
    clk10 = 1'b0;
    step(); step();
    check("hold_single_tick", q.size(), 0);
    scan_frame();

    // Request while busy is dropped.
    value_in = BW'(1234);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    m_value = 1234;
    step(); step();
    value_in = BW'(4321);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    waited = 0;
    while (busy && waited < 40) begin step(); waited++; end
    check("busy_timeout", busy, 1'b0);
    step();
    @(negedge clk);
    check("drop_no_restart", busy, 1'b0);
    step();
    scan_frame();

    // Reset at N+5 aborts the conversion and clears the digits.
    value_in = BW'(5678);
    value_valid = 1'b1;
    step();
    value_valid = 1'b0;
    repeat (4) step();
    mon_en = 1'b0;
    reset = 1'b1;
    step();
    @(negedge clk);
    check("reset_abort_busy", busy, 1'b0);
    do_reset();
    blank = 1'b0;
    scan_frame();

    for (int n = 0; n < 6; n++) begin
      v = int'($urandom_range(0, (1 << BW) - 1));
      blank = 1'($urandom_range(0, 1));
      convert(v);
      scan_frame();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Consumes the 10 kHz divided clock and drives a 4-digit, common-anode, multiplexed seven-segment display.
- Converts a binary score to BCD with a sequential double-dabble FSM.
- Scans one digit per refresh slot, with optional leading-zero blanking and overflow indication.
- Runs entirely in the 100 MHz domain; the 10 kHz signal is sampled as data, never used as a clock.

Parameters:
BIN_WIDTH, 14, width of value_in; values above 9999 are overflow.
REFRESH_TICKS, 10, number of 10 kHz rising edges each digit stays lit (1 kHz digit rate, 250 Hz frame).

Ports:
clk_100mHz_in  input  1  system clock, the only clock.
reset  input  1  synchronous, active-high reset.
clk_10kHz_in  input  1  divided clock from the clock divider, sampled as data.
value_in  input  BIN_WIDTH  binary value to display.
value_valid  input  1  conversion request; accepted only in IDLE.
blank_leading_zeros  input  1  1 = blank leading zero digits.
busy  output  1  conversion in progress.
overflow  output  1  committed value exceeded 9999.
seg_out  output  7  segments {g,f,e,d,c,b,a}, active-low.
dp_out  output  1  decimal point, active-low; held at 1 (off).
an_out  output  4  digit anodes, active-low; an_out[0] = ones digit.

Behaviour:
- Tick detect:
  - prev register samples clk_10kHz_in every cycle; tick = clk_10kHz_in & ~prev.
  - prev resets to 0.
  - A level held high produces one tick only.
- Conversion FSM, states IDLE, SHIFT, COMMIT:
  - IDLE: when value_valid=1 in cycle N, latch value_in, clear the 16-bit BCD scratch and bit counter, go to SHIFT.
  - SHIFT: runs BIN_WIDTH cycles (N+1..N+BIN_WIDTH). Each cycle, add 3 to every scratch nibble >= 5, then shift {scratch, value} left by 1.
  - After the final iteration, go to COMMIT (cycle N+BIN_WIDTH+1). COMMIT copies the scratch to the display digit registers and sets overflow = (latched value > 9999), then returns to IDLE.
  - busy is 1 exactly in cycles N+1..N+BIN_WIDTH+1.
  - New digits are visible from cycle N+BIN_WIDTH+2.
  - value_valid outside IDLE is ignored; the request is dropped, not queued.
  - Display registers hold the old digits throughout conversion, so there is no tearing.
- Scanner:
  - The tick counter counts ticks 0..REFRESH_TICKS-1.
  - On a tick with counter = REFRESH_TICKS-1: counter <= 0, and digit index idx increments, wrapping 3 -> 0.
  - No tick: counter and idx hold.
- Output register:
  - seg_out and an_out are registered from idx and the display registers, one cycle behind an idx change.
  - an_out = ~(4'b0001 << idx).
- Digit selection, with k = idx:
  - If overflow=1: pattern is dash on every digit.
  - Else if blank_leading_zeros=1, k != 0, and digits k..3 are all zero: pattern is blank.
  - Else: pattern is the decimal pattern of digit k.
  - The ones digit is never blanked, so value 0 shows "0".
- Segment encodings, active-low gfedcba:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19
  - 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10
  - dash=7'h3F, blank=7'h7F
- Reset values:
  - state IDLE, busy=0, overflow=0, display digits=0, idx=0, counter=0, prev=0.
  - seg_out=7'h7F, an_out=4'hF, dp_out=1.
  - First cycle after release: an_out=4'hE, seg_out=7'h40.
- Reset asserted mid-conversion aborts the conversion, clears the display digits to 0, and drops busy on the next edge.
- Simultaneous tick and COMMIT: both take effect. The scan advance uses the old idx; the output register picks up the new digits one cycle later.

Test Plan:
1. Reset: hold reset 3 cycles -> seg_out=7'h7F, an_out=4'hF, dp_out=1. One cycle after release -> an_out=4'hE, seg_out=7'h40.
2. Conversion of 1234: value_in=1234, value_valid pulse at cycle N, blank_leading_zeros=0 ->
   - busy=1 for N+1..N+15; overflow=0.
   - Scan shows an_out E/D/B/7 with seg_out 7'h19/7'h30/7'h24/7'h79.
   - Each digit is held for exactly 10 tick edges.
3. Leading-zero blanking: value 7 with blank_leading_zeros=1 -> an_out=E shows 7'h78, other digits show 7'h7F. Same value with blank_leading_zeros=0 -> other digits show 7'h40. Value 0 with blank_leading_zeros=1 -> ones digit shows 7'h40.
4. Overflow: value 12000 -> overflow=1, all digits 7'h3F. Then value 9999 -> overflow=0, all digits 7'h10.
5. Tick edges: hold clk_10kHz_in high for 100 cycles -> exactly one counter advance. Toggle it 20 times (10 rising edges) -> idx advances by exactly 1, wrapping 3 -> 0 after the fourth slot.
6. Dropped request and mid-conversion reset:
   - value_valid=1 with 4321 while busy -> ignored; display shows the first value.
   - reset at N+5 of a conversion -> busy=0 and all digits 0 after reset release.
